// File: rtl/seg7_pkg.sv
// Shared definitions for the two-digit 7-segment scan multiplexer.
package seg7_pkg;

    typedef enum logic [1:0] {
        S_BLANK0 = 2'd0,
        S_DRIVE0 = 2'd1,
        S_BLANK1 = 2'd2,
        S_DRIVE1 = 2'd3
    } seg7_state_t;

    // Active-high "all segments off".
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    localparam int unsigned DIG_UNITS = 0;
    localparam int unsigned DIG_TENS  = 1;

endpackage

// File: rtl/seg7_scan_mux.sv
// Time-multiplexes two 7-segment patterns onto a shared segment bus with
// a blanking gap between digits, tens leading-zero blanking and a frame tick.
//
// state    | meaning
// S_BLANK0 | all anodes off before the units slot
// S_DRIVE0 | units anode on, latched digit0 on the bus
// S_BLANK1 | all anodes off before the tens slot
// S_DRIVE1 | tens anode on (unless blanked), latched digit1 on the bus
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int SLOT_CYCLES    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int CNT_W          = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [6:0] digit1,
    input  logic [6:0] digit0,
    input  logic       blank1,
    output logic [6:0] seg_out,
    output logic [1:0] an_out,
    output logic       frame_tick
);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SLOT_CYCLES - BLANK_CYCLES - 1);
    localparam logic [6:0]       SEG_POL    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0]       AN_POL     = (AN_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    seg7_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       hold0_q, hold0_d;
    logic [6:0]       hold1_q, hold1_d;
    logic             hold_blank1_q, hold_blank1_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] last_cnt;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        hold0_d       = hold0_q;
        hold1_d       = hold1_q;
        hold_blank1_d = hold_blank1_q;
        tick_d        = 1'b0;
        last_cnt      = (state_q == S_BLANK0 || state_q == S_BLANK1) ? BLANK_LAST : DRIVE_LAST;

        if (!en) begin
            state_d = S_BLANK0;
            cnt_d   = '0;
        end else if (cnt_q == last_cnt) begin
            cnt_d = '0;
            case (state_q)
                S_BLANK0: begin
                    state_d = S_DRIVE0;
                    hold0_d = digit0;
                end
                S_DRIVE0: state_d = S_BLANK1;
                S_BLANK1: begin
                    state_d       = S_DRIVE1;
                    hold1_d       = digit1;
                    hold_blank1_d = blank1;
                end
                S_DRIVE1: begin
                    state_d = S_BLANK0;
                    tick_d  = 1'b1;
                end
                default: state_d = S_BLANK0;
            endcase
        end

        // Outputs decode from next state so they switch on the same edge as the state.
        seg_d = SEG_OFF;
        an_d  = 2'b00;
        case (state_d)
            S_DRIVE0: begin
                an_d[DIG_UNITS] = 1'b1;
                seg_d           = hold0_d;
            end
            S_DRIVE1: begin
                if (!hold_blank1_d) begin
                    an_d[DIG_TENS] = 1'b1;
                    seg_d          = hold1_d;
                end
            end
            default: begin
                seg_d = SEG_OFF;
                an_d  = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_BLANK0;
            cnt_q         <= '0;
            hold0_q       <= '0;
            hold1_q       <= '0;
            hold_blank1_q <= 1'b0;
            seg_q         <= SEG_OFF;
            an_q          <= 2'b00;
            tick_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hold0_q       <= hold0_d;
            hold1_q       <= hold1_d;
            hold_blank1_q <= hold_blank1_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            tick_q        <= tick_d;
        end
    end

    assign seg_out    = seg_q ^ SEG_POL;
    assign an_out     = an_q ^ AN_POL;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: directed scan sequence plus randomized traffic
// against a frame-position reference model, on active-high and active-low instances.
module tb_seg7_scan_mux;

    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 2 * SLOT;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       blank1 = 1'b0;
    logic [6:0] digit0 = 7'h00;
    logic [6:0] digit1 = 7'h00;

    logic [6:0] seg_out, seg_out_n;
    logic [1:0] an_out, an_out_n;
    logic       frame_tick, frame_tick_n;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the frame plus the latched patterns.
    int         m_pos;
    logic [6:0] m_lat0, m_lat1;
    logic       m_lb, m_tick;

    always #5 clock = ~clock;

    seg7_scan_mux #(
        .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK), .CNT_W(4),
        .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
    ) u_dut (
        .clock(clock), .reset(reset), .en(en), .digit1(digit1), .digit0(digit0),
        .blank1(blank1), .seg_out(seg_out), .an_out(an_out), .frame_tick(frame_tick)
    );

    seg7_scan_mux #(
        .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK), .CNT_W(4),
        .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) u_dut_n (
        .clock(clock), .reset(reset), .en(en), .digit1(digit1), .digit0(digit0),
        .blank1(blank1), .seg_out(seg_out_n), .an_out(an_out_n), .frame_tick(frame_tick_n)
    );

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_pos  <= 0;
            m_lat0 <= 7'h00;
            m_lat1 <= 7'h00;
            m_lb   <= 1'b0;
            m_tick <= 1'b0;
        end else if (!en) begin
            m_pos  <= 0;
            m_tick <= 1'b0;
        end else begin
            m_pos  <= (m_pos + 1) % FRAME;
            m_tick <= ((m_pos + 1) % FRAME) == 0;
            if ((m_pos + 1) % FRAME == BLANK) m_lat0 <= digit0;
            if ((m_pos + 1) % FRAME == SLOT + BLANK) begin
                m_lat1 <= digit1;
                m_lb   <= blank1;
            end
        end
    end

    task automatic check_exp(input string tag, input logic [6:0] es, input logic [1:0] ea,
                             input logic et);
        checks++;
        assert (seg_out === es) else begin
            errors++;
            $error("FAIL %s seg_out got %h exp %h", tag, seg_out, es);
        end
        checks++;
        assert (an_out === ea) else begin
            errors++;
            $error("FAIL %s an_out got %b exp %b", tag, an_out, ea);
        end
        checks++;
        assert (frame_tick === et) else begin
            errors++;
            $error("FAIL %s frame_tick got %b exp %b", tag, frame_tick, et);
        end
        checks++;
        assert (seg_out_n === ~es) else begin
            errors++;
            $error("FAIL %s seg_out(active-low) got %h exp %h", tag, seg_out_n, ~es);
        end
        checks++;
        assert (an_out_n === ~ea) else begin
            errors++;
            $error("FAIL %s an_out(active-low) got %b exp %b", tag, an_out_n, ~ea);
        end
        checks++;
        assert (frame_tick_n === et) else begin
            errors++;
            $error("FAIL %s frame_tick(active-low inst) got %b exp %b", tag, frame_tick_n, et);
        end
    endtask

    task automatic check_model(input string tag);
        logic [6:0] es;
        logic [1:0] ea;
        es = 7'h00;
        ea = 2'b00;
        if (m_pos >= BLANK && m_pos < SLOT) begin
            es = m_lat0;
            ea = 2'b01;
        end else if (m_pos >= SLOT + BLANK && !m_lb) begin
            es = m_lat1;
            ea = 2'b10;
        end
        check_exp(tag, es, ea, m_tick);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check_exp("reset_state", 7'h00, 2'b00, 1'b0);

        // Basic scan with a mid-slot digit0 change at cycle 4.
        en     = 1'b1;
        digit0 = 7'h06;
        digit1 = 7'h5B;
        reset  = 1'b1;
        for (int c = 0; c < 32; c++) begin
            int         pos;
            logic [6:0] es;
            logic [1:0] ea;
            pos = c % FRAME;
            es  = 7'h00;
            ea  = 2'b00;
            if (pos >= 2 && pos < 8) begin
                ea = 2'b01;
                es = (c >= 18) ? 7'h4F : 7'h06;
            end else if (pos >= 10) begin
                ea = 2'b10;
                es = 7'h5B;
            end
            check_exp("scan_seq", es, ea, c == 16);
            check_model("scan_model");
            if (c == 4) digit0 = 7'h4F;
            @(negedge clock);
        end

        // Leading-zero blanking on the tens digit (cycles 32..47).
        blank1 = 1'b1;
        digit1 = 7'h3F;
        for (int c = 32; c < 48; c++) begin
            check_model("blank1_model");
            if (c >= 42) check_exp("blank1_dark", 7'h00, 2'b00, 1'b0);
            if (c >= 34 && c < 40) check_exp("blank1_units", 7'h4F, 2'b01, 1'b0);
            @(negedge clock);
        end

        // Scan disable mid tens slot, then re-enable.
        blank1 = 1'b0;
        digit1 = 7'h5B;
        for (int c = 48; c < 60; c++) begin
            check_model("pre_en_drop");
            @(negedge clock);
        end
        check_exp("tens_before_drop", 7'h5B, 2'b10, 1'b0);
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check_exp("en_off_dark", 7'h00, 2'b00, 1'b0);
            check_model("en_off_model");
        end
        en = 1'b1;
        @(negedge clock);
        check_exp("reen_blank", 7'h00, 2'b00, 1'b0);
        @(negedge clock);
        check_exp("reen_first_anode", 7'h4F, 2'b01, 1'b0);
        check_model("reen_model");
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check_model("to_drive1");
        end
        check_exp("drive1_before_rst", 7'h5B, 2'b10, 1'b0);

        // Asynchronous reset between edges during the tens slot.
        #1 reset = 1'b0;
        #1 check_exp("async_rst_dark", 7'h00, 2'b00, 1'b0);
        check_model("async_rst_model");
        @(negedge clock);
        check_exp("rst_held", 7'h00, 2'b00, 1'b0);
        reset = 1'b1;
        check_exp("restart_c0", 7'h00, 2'b00, 1'b0);
        @(negedge clock);
        check_exp("restart_c1", 7'h00, 2'b00, 1'b0);
        @(negedge clock);
        check_exp("restart_units", 7'h4F, 2'b01, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            digit0 = 7'($urandom);
            digit1 = 7'($urandom);
            blank1 = 1'($urandom_range(0, 1));
            en     = ($urandom_range(0, 39) != 0);
            @(negedge clock);
            check_model("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Downstream display stage of the two-digit counter. Takes the two 7-segment patterns produced by the BCD-to-7-segment decoders.
- Time-multiplexes the patterns onto one shared segment bus with per-digit anode selects, so a board with common segment lines can show both digits.
- Inserts a blanking gap between digits to prevent ghosting. Provides optional leading-zero blanking and a once-per-frame tick.

Parameters:
- SLOT_CYCLES, 50000, clock cycles per digit slot (blank phase plus drive phase); legal range > BLANK_CYCLES.
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off; legal range >= 1.
- CNT_W, 16, width of the phase counter; must satisfy 2^CNT_W > SLOT_CYCLES.
- SEG_ACTIVE_LOW, 1, 1 = seg_out bit low lights a segment; inputs are always active-high.
- AN_ACTIVE_LOW, 1, 1 = an_out bit low enables a digit.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; 0 = display dark.
- digit1  in  7  tens-digit pattern, active-high, bit0 = segment a.
- digit0  in  7  units-digit pattern, active-high.
- blank1  in  1  leading-zero blank request for the tens digit.
- seg_out  out  7  shared segment bus, polarity per SEG_ACTIVE_LOW.
- an_out  out  2  anode selects; bit1 = tens, bit0 = units; polarity per AN_ACTIVE_LOW.
- frame_tick  out  1  one-cycle pulse at the end of each full two-digit frame.

Behaviour:
- Reset: the clock is one clock; reset is asynchronous and active-low. Reset applies immediately, independent of the clock, and holds while low:
  - state = S_BLANK0, counter = 0, latched patterns = 0.
  - seg_out = all segments off, an_out = both digits off, frame_tick = 0.
- FSM states and cycle counts:
  - S_BLANK0: BLANK_CYCLES cycles.
  - S_DRIVE0 (units): SLOT_CYCLES - BLANK_CYCLES cycles.
  - S_BLANK1: BLANK_CYCLES cycles.
  - S_DRIVE1 (tens): SLOT_CYCLES - BLANK_CYCLES cycles.
  - Then back to S_BLANK0. Frame length = 2 x SLOT_CYCLES cycles.
- Counter: increments every cycle in every state. On the last cycle of a state it clears to 0 and the state advances.
- Pattern capture: on the BLANK->DRIVE transition edge, the digit being driven next is sampled into a holding register (digit0 for S_DRIVE0, digit1 and blank1 for S_DRIVE1). Input changes mid-drive never reach seg_out until the next slot, so there is no tearing.
- Outputs: registered, and decoded from state plus holding register.
  - Blank states: an_out = none, seg_out = off.
  - S_DRIVE0: units anode on, seg_out = latched digit0.
  - S_DRIVE1: tens anode on, seg_out = latched digit1. If latched blank1 = 1, the tens anode stays off and seg_out = off.
  - Outputs change on the same clock edge as the state register. An anode is never active in a cycle when seg_out carries the other digit's pattern.
- frame_tick: high for exactly the one cycle after the S_DRIVE1 -> S_BLANK0 edge (i.e. the first cycle of S_BLANK0).
- en = 0, sampled synchronously: next edge forces state = S_BLANK0, counter = 0, outputs off, frame_tick = 0.
- en 0 -> 1: scanning starts from S_BLANK0 count 0. The first anode turns on BLANK_CYCLES cycles later.
- Reset mid-slot: outputs go dark immediately, and scanning restarts from S_BLANK0 after release.
- Polarity: applied as a final XOR stage only. Internal logic is always active-high.

Decomposition:
- Shared package/header seg7_pkg holds:
  - the state encoding (S_BLANK0=2'd0, S_DRIVE0=2'd1, S_BLANK1=2'd2, S_DRIVE1=2'd3);
  - SEG_OFF = 7'b0000000 (active-high);
  - digit index constants DIG_UNITS=0 and DIG_TENS=1.
- No sub-module. The block is a single FSM plus counter, instantiated next to the two decoders in the top level.

Test Plan (SLOT_CYCLES=8, BLANK_CYCLES=2, both polarity params = 0 unless noted):
- Reset then en=1, digit0=7'h06, digit1=7'h5B, blank1=0:
  - cycles 0-1 dark;
  - cycles 2-7 an_out=2'b01, seg_out=7'h06;
  - cycles 8-9 dark;
  - cycles 10-15 an_out=2'b10, seg_out=7'h5B;
  - frame_tick high at cycle 16 only; pattern repeats every 16 cycles.
- Change digit0 to 7'h4F at cycle 4 (mid S_DRIVE0): seg_out stays 7'h06 through cycle 7, and shows 7'h4F from cycle 18.
- blank1=1, digit1=7'h3F: during S_DRIVE1, an_out=2'b00 and seg_out=0; units digit is unaffected.
- Drop en at cycle 12: dark from cycle 13. Re-raise en: first anode active exactly 2 cycles after the re-enable edge.
- Assert reset asynchronously between edges during S_DRIVE1: an_out and seg_out go off before the next edge. After release, the sequence restarts at S_BLANK0.
- SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1:
  - idle outputs are seg_out=7'h7F, an_out=2'b11;
  - units drive with digit0=7'h06 gives seg_out=7'h79, an_out=2'b10.
